iq_uart_framer: RTL and testbench



---
 rtl/iq_uart_framer.sv | 216 +++++++++++++++++++++
 tb/tb_iq_uart_framer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_uart_framer.sv
// Snapshot framer: NUM_CH samples per strobe are queued and sent as SYNC/SEQ/DATA/XOR frames over UART 8N1.
// First start bit 3 cycles after a strobe into an idle framer; strobes meeting a full FIFO are dropped and counted.
module iq_uart_framer #(
  parameter int          NUM_CH       = 2,
  parameter int          DATA_W       = 32,
  parameter int          CLKS_PER_BIT = 8,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sample_stb,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  output logic                     tx,
  output logic                     busy,
  output logic [15:0]              overflow_cnt,
  output logic [15:0]              frame_cnt
);
  localparam int SW      = NUM_CH * DATA_W;
  localparam int NB      = SW / 8;
  localparam int BPC     = DATA_W / 8;
  localparam int EW      = SW + 8;
  localparam int FRAME_W = (3 + NB) * 8;
  localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW      = $clog2(3 + NB);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(2 + NB);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [BW-1:0]      byte_idx_q, byte_idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d, frame_img;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic [15:0]        ovf_q;
  logic [7:0]         seq_q;
  logic [7:0]         csum, dbyte;
  logic               cap, wr_rdy, fifo_vld, pop, bit_end;
  logic [EW-1:0]      head;

  assign cap = sample_stb & enable;

  // seq advances on every enabled strobe, accepted or not, so drops show up as gaps downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
      ovf_q <= '0;
    end else if (cap) begin
      seq_q <= seq_q + 8'd1;
      if (!wr_rdy && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  iq_uart_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld_i (cap),
    .wr_rdy_o (wr_rdy),
    .wr_dat_i ({seq_q, sample_data}),
    .rd_vld_o (fifo_vld),
    .rd_rdy_i (pop),
    .rd_dat_o (head)
  );

  always_comb begin
    frame_img = '0;
    dbyte     = '0;
    csum      = head[EW-1 -: 8];
    frame_img[7:0]  = SYNC_BYTE;
    frame_img[15:8] = head[EW-1 -: 8];
    for (int j = 0; j < NB; j++) begin
      dbyte = head[(j / BPC) * DATA_W + DATA_W - 8 - 8 * (j % BPC) +: 8];
      frame_img[16 + 8 * j +: 8] = dbyte;
      csum = csum ^ dbyte;
    end
    frame_img[FRAME_W-8 +: 8] = csum;
  end

  assign bit_end = (clk_cnt_q == LAST_CLK);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    fcnt_d     = fcnt_q;
    pop        = 1'b0;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: if (fifo_vld) state_d = LOAD;
      LOAD: begin
        pop        = 1'b1;
        frame_d    = frame_img;
        byte_idx_d = '0;
        clk_cnt_d  = '0;
        state_d    = START;
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          shift_d   = frame_q[7:0];
          frame_d   = frame_q >> 8;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + BW'(1);
            state_d    = START;
          end else begin
            fcnt_d  = fcnt_q + 16'd1;
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from next state so the line is glitch-free and still changes on the state edge.
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      frame_q    <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign tx           = tx_q;
  assign busy         = (state_q != IDLE) | fifo_vld;
  assign overflow_cnt = ovf_q;
  assign frame_cnt    = fcnt_q;
endmodule

// Generic snapshot FIFO; write is accepted when full if a pop happens in the same cycle.
module iq_uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld_i,
  output logic         wr_rdy_o,
  input  logic [W-1:0] wr_dat_i,
  output logic         rd_vld_o,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_dat_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         empty, full, push, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = rd_rdy_i & ~empty;
  assign wr_rdy_o = ~full | pop;
  assign push     = wr_vld_i & wr_rdy_o;
  assign rd_vld_o = ~empty;
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end
endmodule

// File: tb/tb_iq_uart_framer.sv
// Bench for iq_uart_framer: default instance plus a 4x16-bit, 3-clock-per-bit instance, checked against a byte-level frame model.
module tb_iq_uart_framer;
  localparam int CPB0 = 8;
  localparam int CPB1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1, stb0, stb1;
  logic [63:0] dat0, dat1;
  logic        tx0, tx1, busy0, busy1;
  logic [15:0] ovf0, ovf1, fc0, fc1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx0[$], rx1[$], exp0[$], exp1[$];
  int         st0[$], st1[$];
  int         ferr[2] = '{0, 0};
  int         m_off[2] = '{0, 0};
  logic       m_act[2] = '{1'b0, 1'b0};
  logic [9:0] m_first[2], m_last[2];
  logic       mt;
  int         mcpb, mb, mr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iq_uart_framer u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .sample_stb(stb0), .sample_data(dat0),
    .tx(tx0), .busy(busy0), .overflow_cnt(ovf0), .frame_cnt(fc0)
  );

  iq_uart_framer #(.NUM_CH(4), .DATA_W(16), .CLKS_PER_BIT(CPB1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .sample_stb(stb1), .sample_data(dat1),
    .tx(tx1), .busy(busy1), .overflow_cnt(ovf1), .frame_cnt(fc1)
  );

  // UART receiver: each bit is sampled in its first and last cycle; both must agree.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      mt   = (s == 0) ? tx0 : tx1;
      mcpb = (s == 0) ? CPB0 : CPB1;
      if (rst) begin
        m_act[s] = 1'b0;
        ferr[s]  = 0;
        if (s == 0) begin rx0.delete(); st0.delete(); end
        else begin rx1.delete(); st1.delete(); end
      end else begin
        if (!m_act[s] && mt === 1'b0) begin
          m_act[s] = 1'b1;
          m_off[s] = 0;
          if (s == 0) st0.push_back(cyc); else st1.push_back(cyc);
        end
        if (m_act[s]) begin
          mb = m_off[s] / mcpb;
          mr = m_off[s] % mcpb;
          if (mr == 0) m_first[s][mb] = mt;
          if (mr == mcpb - 1) m_last[s][mb] = mt;
          m_off[s] = m_off[s] + 1;
          if (m_off[s] == 10 * mcpb) begin
            m_act[s] = 1'b0;
            if (m_first[s] !== m_last[s] || m_first[s][0] !== 1'b0 || m_first[s][9] !== 1'b1)
              ferr[s] = ferr[s] + 1;
            if (s == 0) rx0.push_back(m_first[s][8:1]); else rx1.push_back(m_first[s][8:1]);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input int s, input logic [7:0] seq, input logic [63:0] d);
    int nch, dw;
    logic [7:0] c, b;
    logic [7:0] f[$];
    nch = (s == 0) ? 2 : 4;
    dw  = (s == 0) ? 32 : 16;
    f.push_back(8'hA5);
    f.push_back(seq);
    c = seq;
    for (int ch = 0; ch < nch; ch++)
      for (int k = dw / 8 - 1; k >= 0; k--) begin
        b = 8'((d >> (ch * dw + 8 * k)) & 64'hFF);
        f.push_back(b);
        c = c ^ b;
      end
    f.push_back(c);
    foreach (f[i]) begin
      if (s == 0) exp0.push_back(f[i]); else exp1.push_back(f[i]);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [63:0] d);
    @(posedge clk); #1;
    if (s == 0) begin stb0 = v; dat0 = d; end
    else begin stb1 = v; dat1 = d; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; stb0 = 1'b0; stb1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
    exp0.delete(); exp1.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_fc(input int s, input int n, input int budget, output int t);
    int i = 0;
    while (((s == 0) ? fc0 : fc1) < 16'(n) && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    t = cyc;
    chk($sformatf("frame_cnt%0d reaches %0d", s, n), (((s == 0) ? fc0 : fc1) >= 16'(n)) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic cmp_bytes(input int s, input string tag);
    logic [7:0] r[$], e[$];
    if (s == 0) begin r = rx0; e = exp0; end
    else begin r = rx1; e = exp1; end
    chk({tag, " byte count"}, r.size(), e.size());
    for (int i = 0; i < e.size() && i < r.size(); i++)
      chk($sformatf("%s byte %0d", tag, i), 32'(r[i]), 32'(e[i]));
    chk({tag, " framing errors"}, ferr[s], 0);
  endtask

  task automatic chk_gaps(input int s, input string tag);
    int q[$];
    int cpb;
    int bad = 0;
    if (s == 0) begin q = st0; cpb = CPB0; end
    else begin q = st1; cpb = CPB1; end
    for (int i = 1; i < q.size(); i++)
      if (q[i] - q[i-1] != ((i % 11 == 0) ? 10 * cpb + 2 : 10 * cpb)) bad++;
    chk({tag, " start-bit spacing"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k;
    logic [63:0] d [6];
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1; stb0 = 1'b0; stb1 = 1'b0; dat0 = '0; dat1 = '0;
    repeat (2) @(negedge clk);
    chk("reset tx0", tx0, 1);
    chk("reset tx1", tx1, 1);
    chk("reset busy0", busy0, 0);
    chk("reset overflow0", ovf0, 0);
    chk("reset frame_cnt0", fc0, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single frame with the known vector
    drive(0, 1'b1, 64'h11223344_AABBCCDD);
    k = cyc;
    model_frame(0, 8'd0, 64'h11223344_AABBCCDD);
    drive(0, 1'b0, {$urandom, $urandom});
    chk("t1 busy after strobe", busy0, 1);
    wait_fc(0, 1, 2000, t);
    chk("t1 first start latency", (st0.size() > 0) ? st0[0] - k : -1, 3);
    chk("t1 frame done cycle", t - k, 883);
    chk("t1 busy falls", busy0, 0);
    chk("t1 checksum", (rx0.size() == 11) ? 32'(rx0[10]) : 32'hFFFF, 8'h44);
    cmp_bytes(0, "t1");

    // overflow: 6 consecutive strobes into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d[i] = {$urandom, $urandom};
      drive(0, 1'b1, d[i]);
    end
    drive(0, 1'b0, '0);
    for (int i = 0; i < 5; i++) model_frame(0, 8'(i), d[i]);
    chk("t2 overflow count", ovf0, 1);
    wait_fc(0, 5, 6000, t);
    chk_gaps(0, "t2");
    d[0] = {$urandom, $urandom};
    drive(0, 1'b1, d[0]);
    drive(0, 1'b0, '0);
    model_frame(0, 8'd6, d[0]);
    wait_fc(0, 6, 2000, t);
    cmp_bytes(0, "t2");
    chk("t2 overflow held", ovf0, 1);

    // back-to-back: two strobes one cycle apart
    do_reset();
    d[0] = {$urandom, $urandom};
    d[1] = {$urandom, $urandom};
    drive(0, 1'b1, d[0]);
    drive(0, 1'b0, '0);
    drive(0, 1'b1, d[1]);
    drive(0, 1'b0, '0);
    model_frame(0, 8'd0, d[0]);
    model_frame(0, 8'd1, d[1]);
    wait_fc(0, 2, 3000, t);
    chk("t3 idle cycles between frames", (st0.size() > 11) ? st0[11] - st0[10] - 10 * CPB0 : -1, 2);
    cmp_bytes(0, "t3");

    // enable gating
    do_reset();
    en0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, {$urandom, $urandom});
      drive(0, 1'b0, '0);
    end
    repeat (20) @(posedge clk); #1;
    chk("t4 no tx while disabled", st0.size(), 0);
    chk("t4 busy while disabled", busy0, 0);
    chk("t4 overflow while disabled", ovf0, 0);
    en0 = 1'b1;
    d[0] = {$urandom, $urandom};
    drive(0, 1'b1, d[0]);
    drive(0, 1'b0, '0);
    model_frame(0, 8'd0, d[0]);
    repeat (300) @(posedge clk); #1 en0 = 1'b0;
    drive(0, 1'b1, {$urandom, $urandom});
    drive(0, 1'b0, '0);
    wait_fc(0, 1, 2000, t);
    repeat (20) @(posedge clk); #1;
    chk("t4 frames after enable drop", fc0, 1);
    cmp_bytes(0, "t4");
    en0 = 1'b1;

    // reset asserted during byte 4
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 1'b1, {$urandom, $urandom});
    drive(0, 1'b0, '0);
    chk("t5 overflow before reset", ovf0, 1);
    k = 0;
    while (st0.size() < 5 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t5 reached byte 4", st0.size(), 5);
    chk("t5 tx low before reset", tx0, 0);
    #1 rst = 1'b1;
    #1;
    chk("t5 tx async high", tx0, 1);
    chk("t5 frame_cnt cleared", fc0, 0);
    chk("t5 overflow cleared", ovf0, 0);
    chk("t5 busy cleared", busy0, 0);
    do_reset();
    d[0] = {$urandom, $urandom};
    drive(0, 1'b1, d[0]);
    drive(0, 1'b0, '0);
    model_frame(0, 8'd0, d[0]);
    wait_fc(0, 1, 2000, t);
    chk("t5 seq restarts", (rx0.size() > 1) ? 32'(rx0[1]) : 32'hFFFF, 0);
    cmp_bytes(0, "t5");

    // parameter sweep instance: 4 channels x 16 bits, 3 clocks per bit
    do_reset();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom};
      drive(1, 1'b1, d[i]);
      if (i == 0) k = cyc;
      model_frame(1, 8'(i), d[i]);
    end
    drive(1, 1'b0, '0);
    wait_fc(1, 3, 3000, t);
    chk("t6 first start latency", (st1.size() > 0) ? st1[0] - k : -1, 3);
    chk("t6 three frames done cycle", t - k, 3 + 3 * 11 * 10 * CPB1 + 2 * 2);
    chk_gaps(1, "t6");
    cmp_bytes(1, "t6");
    chk("t6 other instance idle", st0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
